// File: rtl/fetch_queue_pkg.sv
// Shared definitions for the instruction-fetch front end.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fetch_queue_pkg;

  localparam int          XLEN     = 32;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  // One queue entry: the fetched PC and the instruction word returned for it.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_sync_fifo.sv
// Generic synchronous FIFO with clear, occupancy count and head-of-queue output.
// Latency: a pushed word is visible at head_dat the cycle after the push.
// Backpressure: none internally; the caller never pushes when full unless it also pops.
// Ports: clk, rst_n (sync, active-low), clear, push/push_dat, pop, count, head_dat.
module fetch_queue_sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_dat,
  input  logic                       pop,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [WIDTH-1:0]           head_dat
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             mem_wr_en;
  logic [WIDTH-1:0] mem_q [DEPTH];

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    mem_wr_en = 1'b0;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // DEPTH is a power of two, so pointers wrap naturally.
      mem_wr_en = push;
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Push+pop while full writes the slot being read; the head is sampled before the write lands.
  always_ff @(posedge clk) begin
    if (mem_wr_en) mem_q[wr_ptr_q] <= push_dat;
  end

  assign count    = count_q;
  assign head_dat = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: sequential PC generator, credit-limited MMU reads, decoupling queue to decode.
// Latency: response to INST_VALID is 1 cycle (0 cycles on an empty queue when FETCH_QUEUE_BYPASS_EN is defined).
// Backpressure: INST_READY=0 fills the queue; requests stop once in-flight reads plus queued entries reach QUEUE_DEPTH.
// Ports: CLK, RST_N (sync, active-low); FLUSH/NEW_PC redirect; MEM_WAIT, INST_RDEN, INST_RIADDR request side;
//        INST_RVALID, INST_ROADDR, INST_RDATA response side; INST_VALID, INST_READY, INST_PC, INST_DATA to decode.
// Optional macro: FETCH_QUEUE_BYPASS_EN enables the empty-queue combinational response bypass.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter logic [31:0] START_ADDR      = 32'h2000_0000,
  parameter int          QUEUE_DEPTH     = 4,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            FLUSH,
  input  logic [XLEN-1:0] NEW_PC,
  input  logic            MEM_WAIT,
  output logic            INST_RDEN,
  output logic [XLEN-1:0] INST_RIADDR,
  input  logic            INST_RVALID,
  input  logic [XLEN-1:0] INST_ROADDR,
  input  logic [XLEN-1:0] INST_RDATA,
  output logic            INST_VALID,
  input  logic            INST_READY,
  output logic [XLEN-1:0] INST_PC,
  output logic [XLEN-1:0] INST_DATA
);

  localparam int OW = $clog2(MAX_OUTSTANDING+1);
  localparam int CW = $clog2(QUEUE_DEPTH+1);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [OW-1:0]   outstanding_q, outstanding_d;
  logic [OW-1:0]   drop_q, drop_d;

  logic            accept;
  logic            rsp_vld;
  logic            rsp_keep;
  logic            byp_vld;
  logic            push;
  logic            pop;
  logic [CW-1:0]   q_count;
  logic            q_nonempty;
  fetch_entry_t    q_head;
  fetch_entry_t    rsp_entry;

  assign q_nonempty = (q_count != '0);
  assign rsp_entry  = '{pc: INST_ROADDR, inst: INST_RDATA};

  // A response with nothing in flight can only be a leftover from before reset; ignore it.
  assign rsp_vld  = RST_N && INST_RVALID && (outstanding_q != '0);
  assign rsp_keep = rsp_vld && (drop_q == '0) && !FLUSH;

  // Credit: every accepted read is guaranteed a queue slot when it returns.
  assign INST_RDEN   = RST_N && !FLUSH && (outstanding_q < OW'(MAX_OUTSTANDING))
                     && ((32'(outstanding_q) + 32'(q_count)) < 32'(QUEUE_DEPTH));
  assign INST_RIADDR = FLUSH ? '0 : pc_q;
  assign accept      = INST_RDEN && !MEM_WAIT;

`ifdef FETCH_QUEUE_BYPASS_EN
  assign byp_vld = rsp_keep && !q_nonempty;
`else
  assign byp_vld = 1'b0;
`endif

  // A bypassed response taken by decode this cycle never enters the queue.
  assign push = rsp_keep && !(byp_vld && INST_READY);
  assign pop  = q_nonempty && INST_READY && !FLUSH;

  always_comb begin
    INST_VALID = 1'b0;
    INST_PC    = '0;
    INST_DATA  = NOP_INST;
    if (q_nonempty) begin
      INST_VALID = 1'b1;
      INST_PC    = q_head.pc;
      INST_DATA  = q_head.inst;
    end else if (byp_vld) begin
      INST_VALID = 1'b1;
      INST_PC    = INST_ROADDR;
      INST_DATA  = INST_RDATA;
    end
  end

  always_comb begin
    pc_d          = pc_q;
    drop_d        = drop_q;
    outstanding_d = outstanding_q + OW'(accept) - OW'(rsp_vld);
    if (FLUSH) begin
      pc_d   = NEW_PC;
      // Every read still in flight after this cycle belongs to the old stream,
      // including any not yet dropped from an earlier flush.
      drop_d = outstanding_q - OW'(rsp_vld);
    end else begin
      if (accept) pc_d = pc_q + 32'd4;
      if (rsp_vld && (drop_q != '0)) drop_d = drop_q - OW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      pc_q          <= START_ADDR;
      outstanding_q <= '0;
      drop_q        <= '0;
    end else begin
      pc_q          <= pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
    end
  end

  fetch_queue_sync_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clk      (CLK),
    .rst_n    (RST_N),
    .clear    (FLUSH),
    .push     (push),
    .push_dat (rsp_entry),
    .pop      (pop),
    .count    (q_count),
    .head_dat (q_head)
  );

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with a fixed-latency in-order MMU model driven from the stimulus thread.
module tb_fetch_queue;

  logic        CLK;
  logic        RST_N;
  logic        FLUSH;
  logic [31:0] NEW_PC;
  logic        MEM_WAIT;
  logic        INST_RDEN;
  logic [31:0] INST_RIADDR;
  logic        INST_RVALID;
  logic [31:0] INST_ROADDR;
  logic [31:0] INST_RDATA;
  logic        INST_VALID;
  logic        INST_READY;
  logic [31:0] INST_PC;
  logic [31:0] INST_DATA;

  localparam logic [31:0] NOP = 32'h0000_0013;

  int errors = 0;
  int checks = 0;

  int          lat;
  logic        pv [4];
  logic [31:0] pa [4];

  fetch_queue dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .FLUSH       (FLUSH),
    .NEW_PC      (NEW_PC),
    .MEM_WAIT    (MEM_WAIT),
    .INST_RDEN   (INST_RDEN),
    .INST_RIADDR (INST_RIADDR),
    .INST_RVALID (INST_RVALID),
    .INST_ROADDR (INST_ROADDR),
    .INST_RDATA  (INST_RDATA),
    .INST_VALID  (INST_VALID),
    .INST_READY  (INST_READY),
    .INST_PC     (INST_PC),
    .INST_DATA   (INST_DATA)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return ~a;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; the MMU model records an accepted request and returns it `lat` cycles later.
  task automatic tick();
    logic        acc;
    logic [31:0] a;
    acc = INST_RDEN && !MEM_WAIT;
    a   = INST_RIADDR;
    @(posedge CLK);
    #1;
    for (int i = 3; i > 0; i--) begin
      pv[i] = pv[i-1];
      pa[i] = pa[i-1];
    end
    pv[0] = acc;
    pa[0] = a;
    INST_RVALID = pv[lat-1];
    INST_ROADDR = pa[lat-1];
    INST_RDATA  = data_of(pa[lat-1]);
    #1;
  endtask

  task automatic restart(input int l);
    RST_N      = 1'b0;
    FLUSH      = 1'b0;
    NEW_PC     = '0;
    MEM_WAIT   = 1'b0;
    INST_READY = 1'b0;
    lat        = l;
    for (int i = 0; i < 4; i++) begin
      pv[i] = 1'b0;
      pa[i] = '0;
    end
    INST_RVALID = 1'b0;
    INST_ROADDR = '0;
    INST_RDATA  = '0;
    #1;
    check("rden_in_reset", INST_RDEN, 32'd0);
    tick();
    tick();
    RST_N = 1'b1;
    #1;
    check("reset_valid", INST_VALID, 32'd0);
    check("reset_pc", INST_PC, 32'd0);
    check("reset_data", INST_DATA, NOP);
  endtask

  initial begin
    // 1: back-to-back fetch, 1-cycle MMU, decode always ready
    restart(1);
    INST_READY = 1'b1;
    #1;
    check("t1_rden_c0", INST_RDEN, 32'd1);
    check("t1_addr_c0", INST_RIADDR, 32'h2000_0000);
    tick();
    check("t1_addr_c1", INST_RIADDR, 32'h2000_0004);
    check("t1_valid_c1", INST_VALID, 32'd0);
    tick();
    check("t1_addr_c2", INST_RIADDR, 32'h2000_0008);
    check("t1_valid_c2", INST_VALID, 32'd1);
    check("t1_pc_c2", INST_PC, 32'h2000_0000);
    check("t1_data_c2", INST_DATA, 32'hDFFF_FFFF);
    tick();
    check("t1_pc_c3", INST_PC, 32'h2000_0004);
    check("t1_data_c3", INST_DATA, 32'hDFFF_FFFB);

    // 2: decode stalled, queue fills to exactly QUEUE_DEPTH, then drains in order
    restart(1);
    #1;
    for (int i = 0; i < 4; i++) begin
      check("t2_fill_rden", INST_RDEN, 32'd1);
      check("t2_fill_addr", INST_RIADDR, 32'h2000_0000 + 32'(4 * i));
      tick();
    end
    check("t2_stop_rden_c4", INST_RDEN, 32'd0);
    tick();
    check("t2_stop_rden_c5", INST_RDEN, 32'd0);
    INST_READY = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      check("t2_drain_valid", INST_VALID, 32'd1);
      check("t2_drain_pc", INST_PC, 32'h2000_0000 + 32'(4 * i));
      check("t2_drain_data", INST_DATA, data_of(32'h2000_0000 + 32'(4 * i)));
      if (i == 1) begin
        check("t2_resume_rden", INST_RDEN, 32'd1);
        check("t2_resume_addr", INST_RIADDR, 32'h2000_0010);
      end
      tick();
    end
    check("t2_next_pc", INST_PC, 32'h2000_0010);

    // 3: MEM_WAIT holds the request stable for three cycles
    restart(1);
    INST_READY = 1'b1;
    MEM_WAIT   = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      check("t3_wait_rden", INST_RDEN, 32'd1);
      check("t3_wait_addr", INST_RIADDR, 32'h2000_0000);
      tick();
    end
    MEM_WAIT = 1'b0;
    #1;
    check("t3_go_rden", INST_RDEN, 32'd1);
    check("t3_go_addr", INST_RIADDR, 32'h2000_0000);
    tick();
    check("t3_next_addr", INST_RIADDR, 32'h2000_0004);
    check("t3_valid_c4", INST_VALID, 32'd0);
    tick();
    check("t3_valid_c5", INST_VALID, 32'd1);
    check("t3_pc_c5", INST_PC, 32'h2000_0000);

    // 4: 3-cycle MMU, flush with two reads outstanding
    restart(3);
    INST_READY = 1'b1;
    #1;
    check("t4_addr_c0", INST_RIADDR, 32'h2000_0000);
    tick();
    check("t4_addr_c1", INST_RIADDR, 32'h2000_0004);
    tick();
    check("t4_credit_rden", INST_RDEN, 32'd0);
    FLUSH  = 1'b1;
    NEW_PC = 32'h2000_0100;
    #1;
    check("t4_flush_rden", INST_RDEN, 32'd0);
    check("t4_flush_addr", INST_RIADDR, 32'd0);
    tick();
    FLUSH  = 1'b0;
    NEW_PC = '0;
    #1;
    for (int i = 0; i < 5; i++) begin
      check("t4_no_stale_valid", INST_VALID, 32'd0);
      if (i == 1) begin
        check("t4_restart_rden", INST_RDEN, 32'd1);
        check("t4_restart_addr", INST_RIADDR, 32'h2000_0100);
      end
      tick();
    end
    check("t4_valid", INST_VALID, 32'd1);
    check("t4_pc", INST_PC, 32'h2000_0100);
    check("t4_data", INST_DATA, data_of(32'h2000_0100));

    // 5: flush in the same cycle as a response and a pop
    restart(1);
    INST_READY = 1'b1;
    #1;
    tick();
    tick();
    FLUSH  = 1'b1;
    NEW_PC = 32'h3000_0000;
    #1;
    check("t5_flush_rvalid", INST_RVALID, 32'd1);
    check("t5_flush_rden", INST_RDEN, 32'd0);
    check("t5_flush_addr", INST_RIADDR, 32'd0);
    tick();
    FLUSH  = 1'b0;
    NEW_PC = '0;
    #1;
    check("t5_empty_valid", INST_VALID, 32'd0);
    check("t5_empty_pc", INST_PC, 32'd0);
    check("t5_empty_data", INST_DATA, NOP);
    check("t5_new_rden", INST_RDEN, 32'd1);
    check("t5_new_addr", INST_RIADDR, 32'h3000_0000);
    tick();
    check("t5_valid_c4", INST_VALID, 32'd0);
    check("t5_addr_c4", INST_RIADDR, 32'h3000_0004);
    tick();
    check("t5_valid_c5", INST_VALID, 32'd1);
    check("t5_pc_c5", INST_PC, 32'h3000_0000);

    // 6: PC wrap, then reset mid-burst with a late response arriving after reset
    restart(2);
    INST_READY = 1'b1;
    FLUSH      = 1'b1;
    NEW_PC     = 32'hFFFF_FFFC;
    #1;
    check("t6_flush_rden", INST_RDEN, 32'd0);
    tick();
    FLUSH  = 1'b0;
    NEW_PC = '0;
    #1;
    check("t6_addr_top", INST_RIADDR, 32'hFFFF_FFFC);
    tick();
    check("t6_wrap_rden", INST_RDEN, 32'd1);
    check("t6_wrap_addr", INST_RIADDR, 32'h0000_0000);
    tick();
    RST_N = 1'b0;
    #1;
    check("t6_rst_rden", INST_RDEN, 32'd0);
    tick();
    RST_N = 1'b1;
    #1;
    check("t6_post_rst_valid", INST_VALID, 32'd0);
    check("t6_post_rst_data", INST_DATA, NOP);
    check("t6_post_rst_pc", INST_PC, 32'd0);
    check("t6_post_rst_addr", INST_RIADDR, 32'h2000_0000);
    tick();
    check("t6_late_ignored_c5", INST_VALID, 32'd0);
    tick();
    check("t6_valid_c6", INST_VALID, 32'd0);
    tick();
    check("t6_valid_c7", INST_VALID, 32'd1);
    check("t6_pc_c7", INST_PC, 32'h2000_0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
